// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational instruction-memory port between the
// core fetch unit (word reads) and the program loader (byte-enabled writes).
// Each accepted request is registered and occupies exactly one memory cycle.
// Read data is returned one cycle later. Misaligned or out-of-range
// addresses are flagged on err_o.
module imem_arbiter #(
  parameter int unsigned MEM_BYTES    = 1024,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_i,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        ldr_req_i,
  input  logic [31:0] ldr_addr_i,
  input  logic [31:0] ldr_wdata_i,
  input  logic [3:0]  ldr_be_i,
  output logic        ldr_gnt_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CORE = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  // Highest legal word address; the compare is a plain 32-bit unsigned one.
  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);
  // One spare code so the counter can hold STARVE_LIMIT itself.
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          aerr_q, aerr_d;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic          cerr_q;

  logic core_cand;
  logic ldr_cand;
  logic ldr_win;
  logic core_win;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > MAX_ADDR);
  endfunction

  // A requester in its grant cycle is not re-sampled, so each side gets at
  // most one access every two cycles and alternating traffic runs back-to-back.
  assign core_cand = core_req_i && !boot_i && !core_gnt_o;
  assign ldr_cand  = ldr_req_i && !ldr_gnt_o;
  assign ldr_win   = ldr_cand && (!core_cand || (starve_q == STARVE_MAX));
  assign core_win  = core_cand && !ldr_win;

  // Arbitration: pick the winner, latch its request, update the starve count.
  always_comb begin
    state_d  = ST_IDLE;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    aerr_d   = aerr_q;
    starve_d = starve_q;
    if (ldr_win) begin
      state_d = ST_LOAD;
      addr_d  = ldr_addr_i;
      wdata_d = ldr_wdata_i;
      be_d    = ldr_be_i;
      aerr_d  = addr_bad(ldr_addr_i);
    end else if (core_win) begin
      state_d = ST_CORE;
      addr_d  = core_addr_i;
      wdata_d = 32'h0;
      be_d    = 4'h0;
      aerr_d  = addr_bad(core_addr_i);
    end
    // Loader losing while a candidate is the only way to count up; a win
    // at the limit clears it, so the count never passes STARVE_LIMIT.
    if (!ldr_req_i || ldr_win) begin
      starve_d = '0;
    end else if (ldr_cand && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // State, starve count and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      aerr_q   <= aerr_d;
    end
  end

  // Read return: capture memory data (or the NOP substitute) at the end of
  // the CORE cycle; rdata holds until the next valid read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      cerr_q   <= 1'b0;
    end else begin
      rvalid_q <= (state_q == ST_CORE);
      cerr_q   <= (state_q == ST_CORE) && aerr_q;
      if (state_q == ST_CORE) begin
        rdata_q <= aerr_q ? NOP_WORD : mem_rdata_i;
      end
    end
  end

  assign core_gnt_o    = (state_q == ST_CORE);
  assign ldr_gnt_o     = (state_q == ST_LOAD);
  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;

  // Memory port is quiet outside a grant; an erroneous write never strobes.
  assign mem_addr_o  = (core_gnt_o || ldr_gnt_o) ? addr_q : 32'h0;
  assign mem_we_o    = ldr_gnt_o && !aerr_q;
  assign mem_be_o    = ldr_gnt_o ? be_q : 4'h0;
  assign mem_wdata_o = ldr_gnt_o ? wdata_q : 32'h0;

  assign err_o = cerr_q || (ldr_gnt_o && aerr_q);

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a byte-enabled word memory model on the memory
// port, a scoreboard of expected read returns pushed as core accesses are
// issued, and one task per scenario. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_imem_arbiter;

  localparam int unsigned MEM_BYTES    = 1024;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic [31:0] core_addr_i = 32'h0;
  logic        core_gnt_o;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        ldr_req_i = 1'b0;
  logic [31:0] ldr_addr_i = 32'h0;
  logic [31:0] ldr_wdata_i = 32'h0;
  logic [3:0]  ldr_be_i = 4'h0;
  logic        ldr_gnt_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  imem_arbiter #(
    .MEM_BYTES(MEM_BYTES),
    .STARVE_LIMIT(STARVE_LIMIT),
    .NOP_WORD(32'h0000_0013)
  ) dut (
    .clk(clk), .rst_n(rst_n), .boot_i(boot_i),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .ldr_req_i(ldr_req_i), .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
    .ldr_be_i(ldr_be_i), .ldr_gnt_o(ldr_gnt_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, byte-enabled write on the rising edge.
  logic [31:0] mem_arr [0:255];
  assign mem_rdata_i = mem_arr[mem_addr_o[9:2]];
  always @(posedge clk) begin
    if (mem_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_o[b]) mem_arr[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  rd_exp_t     mon_e;
  logic        mon_err;
  int          checks = 0;
  int          errors = 0;

  // Expectations for the request currently being issued by a task.
  logic [31:0] exp_core_word = 32'h0;
  logic        exp_core_err = 1'b0;
  logic [31:0] exp_ldr_addr = 32'h0;
  logic [31:0] exp_ldr_data = 32'h0;
  logic [3:0]  exp_ldr_be = 4'h0;
  logic        exp_ldr_err = 1'b0;

  // Monitor: pops read returns, checks every write and the err_o pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_err = 1'b0;
      if (core_rvalid_o) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: got rvalid with rdata=%h, none expected", core_rdata_o);
        end else begin
          mon_e = rd_q.pop_front();
          mon_err = mon_e.err;
          $display("read  rdata=%h expected=%h", core_rdata_o, mon_e.word);
          if (core_rdata_o !== mon_e.word) begin
            errors++;
            $display("FAIL rdata: got %h, expected %h", core_rdata_o, mon_e.word);
          end
        end
      end
      if (core_gnt_o) begin
        rd_q.push_back('{word: exp_core_word, err: exp_core_err});
      end
      if (ldr_gnt_o) begin
        checks++;
        $display("write addr=%h data=%h be=%b we=%b", mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o);
        if ({mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o} !==
            {exp_ldr_addr, exp_ldr_data, exp_ldr_be, !exp_ldr_err}) begin
          errors++;
          $display("FAIL ldr_write: got addr=%h data=%h be=%b we=%b, expected addr=%h data=%h be=%b we=%b",
                   mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o,
                   exp_ldr_addr, exp_ldr_data, exp_ldr_be, !exp_ldr_err);
        end
      end else if (mem_we_o) begin
        checks++;
        errors++;
        $display("FAIL stray_write: got mem_we_o=1 addr=%h without ldr_gnt_o, expected 0", mem_addr_o);
      end
      checks++;
      if (err_o !== (mon_err | (ldr_gnt_o & exp_ldr_err))) begin
        errors++;
        $display("FAIL err_o: got %b, expected %b", err_o, mon_err | (ldr_gnt_o & exp_ldr_err));
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({core_gnt_o, core_rvalid_o, core_rdata_o, ldr_gnt_o, mem_addr_o, mem_we_o,
         mem_be_o, mem_wdata_o, err_o} !== 105'h0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b/%b rvalid=%b rdata=%h addr=%h we=%b, expected all 0",
               core_gnt_o, ldr_gnt_o, core_rvalid_o, core_rdata_o, mem_addr_o, mem_we_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_core_read();
    @(negedge clk);
    exp_core_word = 32'hDEAD_BEEF;
    exp_core_err  = 1'b0;
    core_addr_i   = 32'h10;
    core_req_i    = 1'b1;
    @(negedge clk);
    checks++;
    if ({core_gnt_o, mem_addr_o, mem_we_o} !== {1'b1, 32'h10, 1'b0}) begin
      errors++;
      $display("FAIL core_read_gnt: got gnt=%b addr=%h we=%b, expected 1/00000010/0",
               core_gnt_o, mem_addr_o, mem_we_o);
    end
    core_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL core_read_rvalid: got rvalid=%b rdata=%h, expected 1/deadbeef", core_rvalid_o, core_rdata_o);
    end
    @(negedge clk);
    checks++;
    if ({core_rvalid_o, core_rdata_o} !== {1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL core_read_hold: got rvalid=%b rdata=%h, expected 0/deadbeef", core_rvalid_o, core_rdata_o);
    end
  endtask

  task automatic test_boot();
    @(negedge clk);
    exp_core_word = 32'hDEAD_BEEF;
    exp_core_err  = 1'b0;
    exp_ldr_addr  = 32'h40;
    exp_ldr_data  = 32'hA5A5_A5A5;
    exp_ldr_be    = 4'hF;
    exp_ldr_err   = 1'b0;
    boot_i = 1'b1;
    core_addr_i = 32'h10; core_req_i = 1'b1;
    ldr_addr_i = 32'h40; ldr_wdata_i = 32'hA5A5_A5A5; ldr_be_i = 4'hF; ldr_req_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({core_gnt_o, ldr_gnt_o} !== {1'b0, (k % 2) == 1}) begin
        errors++;
        $display("FAIL boot_grant k=%0d: got core_gnt=%b ldr_gnt=%b, expected 0/%b",
                 k, core_gnt_o, ldr_gnt_o, (k % 2) == 1);
      end
    end
    core_req_i = 1'b0; ldr_req_i = 1'b0; boot_i = 1'b0;
  endtask

  task automatic test_contention();
    int waited;
    @(negedge clk);
    exp_core_word = 32'hDEAD_BEEF;
    exp_core_err  = 1'b0;
    exp_ldr_addr  = 32'h44;
    exp_ldr_data  = 32'h5A5A_0001;
    exp_ldr_be    = 4'hF;
    exp_ldr_err   = 1'b0;
    core_addr_i = 32'h10; core_req_i = 1'b1;
    ldr_addr_i = 32'h44; ldr_wdata_i = 32'h5A5A_0001; ldr_be_i = 4'hF; ldr_req_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({core_gnt_o, ldr_gnt_o} !== {(k % 2) == 1, (k % 2) == 0}) begin
        errors++;
        $display("FAIL contention_alt k=%0d: got core_gnt=%b ldr_gnt=%b, expected %b/%b",
                 k, core_gnt_o, ldr_gnt_o, (k % 2) == 1, (k % 2) == 0);
      end
    end
    // Core alone for a while, then the loader comes back.
    ldr_req_i = 1'b0;
    repeat (3) @(negedge clk);
    ldr_req_i = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ldr_gnt_o && waited < 4 * STARVE_LIMIT + 4);
    ldr_req_i = 1'b0;
    checks++;
    if (!ldr_gnt_o || waited > STARVE_LIMIT + 1) begin
      errors++;
      $display("FAIL starve_bound: got ldr_gnt=%b after %0d cycles, expected grant within %0d",
               ldr_gnt_o, waited, STARVE_LIMIT + 1);
    end
    core_req_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_errors();
    @(negedge clk);
    exp_core_word = 32'h0000_0013;
    exp_core_err  = 1'b1;
    core_addr_i = 32'h2; core_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if (core_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_gnt: got core_gnt=%b, expected 1", core_gnt_o);
    end
    core_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_rvalid_o, core_rdata_o, err_o} !== {1'b1, 32'h0000_0013, 1'b1}) begin
      errors++;
      $display("FAIL misaligned_read: got rvalid=%b rdata=%h err=%b, expected 1/00000013/1",
               core_rvalid_o, core_rdata_o, err_o);
    end
    exp_ldr_addr = 32'h400;
    exp_ldr_data = 32'hFFFF_FFFF;
    exp_ldr_be   = 4'hF;
    exp_ldr_err  = 1'b1;
    ldr_addr_i = 32'h400; ldr_wdata_i = 32'hFFFF_FFFF; ldr_be_i = 4'hF; ldr_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({ldr_gnt_o, err_o, mem_we_o} !== 3'b110) begin
      errors++;
      $display("FAIL range_write: got gnt=%b err=%b we=%b, expected 1/1/0", ldr_gnt_o, err_o, mem_we_o);
    end
    ldr_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({err_o, mem_arr[0]} !== {1'b0, 32'h0BAD_C0DE}) begin
      errors++;
      $display("FAIL range_after: got err=%b word0=%h, expected 0/0badc0de", err_o, mem_arr[0]);
    end
    exp_ldr_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    exp_ldr_addr = 32'h8;
    exp_ldr_data = 32'hCAFE_F00D;
    exp_ldr_be   = 4'b0011;
    exp_ldr_err  = 1'b0;
    ldr_addr_i = 32'h8; ldr_wdata_i = 32'hCAFE_F00D; ldr_be_i = 4'b0011; ldr_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({ldr_gnt_o, mem_we_o, mem_be_o} !== {1'b1, 1'b1, 4'b0011}) begin
      errors++;
      $display("FAIL b2b_write: got gnt=%b we=%b be=%b, expected 1/1/0011", ldr_gnt_o, mem_we_o, mem_be_o);
    end
    ldr_req_i = 1'b0;
    exp_core_word = 32'h1234_F00D;
    exp_core_err  = 1'b0;
    core_addr_i = 32'h8; core_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({core_gnt_o, ldr_gnt_o, mem_addr_o} !== {1'b1, 1'b0, 32'h8}) begin
      errors++;
      $display("FAIL b2b_read_gnt: got core_gnt=%b ldr_gnt=%b addr=%h, expected 1/0/00000008",
               core_gnt_o, ldr_gnt_o, mem_addr_o);
    end
    core_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_rvalid_o, core_rdata_o, mem_arr[2]} !== {1'b1, 32'h1234_F00D, 32'h1234_F00D}) begin
      errors++;
      $display("FAIL b2b_merge: got rvalid=%b rdata=%h mem=%h, expected 1/1234f00d/1234f00d",
               core_rvalid_o, core_rdata_o, mem_arr[2]);
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    exp_ldr_addr = 32'h20;
    exp_ldr_data = 32'h1111_1111;
    exp_ldr_be   = 4'hF;
    exp_ldr_err  = 1'b0;
    ldr_addr_i = 32'h20; ldr_wdata_i = 32'h1111_1111; ldr_be_i = 4'hF; ldr_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({ldr_gnt_o, mem_we_o} !== 2'b11) begin
      errors++;
      $display("FAIL midload_gnt: got gnt=%b we=%b, expected 1/1", ldr_gnt_o, mem_we_o);
    end
    #1;
    rst_n = 1'b0;
    ldr_req_i = 1'b0;
    #1;
    checks++;
    if ({core_gnt_o, core_rvalid_o, core_rdata_o, ldr_gnt_o, mem_addr_o, mem_we_o,
         mem_be_o, mem_wdata_o, err_o} !== 105'h0) begin
      errors++;
      $display("FAIL midload_reset: got we=%b gnt=%b addr=%h rdata=%h, expected all 0",
               mem_we_o, ldr_gnt_o, mem_addr_o, core_rdata_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_arr[8] !== 32'h0) begin
      errors++;
      $display("FAIL midload_nowrite: got word@0x20=%h, expected 00000000", mem_arr[8]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[0] = 32'h0BAD_C0DE;
    mem_arr[2] = 32'h1234_5678;
    mem_arr[4] = 32'hDEAD_BEEF;

    test_reset();
    test_core_read();
    test_boot();
    test_contention();
    test_errors();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d reads outstanding, expected 0", rd_q.size());
    end
    test_reset_mid_load();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
